// File: rtl/writeback_trace_capture.sv
// writeback_trace_capture
// Mirrors processor register writebacks into a 32-entry shadow register file.
// Each writeback to a non-zero register is also queued in a trace FIFO for an
// external consumer using a valid/ready handshake.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   wb_valid/addr/data - writeback observed from the processor
//   rd_addr/rd_data - shadow register file read port (no write bypass)
//   trace_valid/ready/addr/data - FIFO head and consumer handshake
//   trace_count     - FIFO occupancy
//   overflow        - sticky flag, a writeback was dropped on a full FIFO
//   drop_count      - saturating count of dropped writebacks
//   wb_count        - wrapping count of all wb_valid cycles
module writeback_trace_capture #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic [4:0]    wb_addr,
  input  logic [31:0]   wb_data,
  input  logic [4:0]    rd_addr,
  output logic [31:0]   rd_data,
  output logic          trace_valid,
  input  logic          trace_ready,
  output logic [4:0]    trace_addr,
  output logic [31:0]   trace_data,
  output logic [AW:0]   trace_count,
  output logic          overflow,
  output logic [7:0]    drop_count,
  output logic [15:0]   wb_count
);

  localparam int unsigned CW = AW + 1;

  logic [31:0]   shadow [32];
  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic wb_write;
  logic full;
  logic push;
  logic pop;
  logic drop;

  // Handshake decode; a full FIFO still accepts a push when the head leaves.
  always_comb begin
    wb_write    = wb_valid && (wb_addr != 5'd0);
    full        = (trace_count == CW'(DEPTH));
    trace_valid = (trace_count != CW'(0));
    pop         = trace_valid && trace_ready;
    push        = wb_write && (!full || pop);
    drop        = wb_write && full && !pop;
  end

  // Read ports: register 0 reads as zero, head is masked to zero when empty.
  always_comb begin
    rd_data    = (rd_addr == 5'd0) ? 32'd0 : shadow[rd_addr];
    trace_addr = trace_valid ? fifo_addr[rd_ptr] : 5'd0;
    trace_data = trace_valid ? fifo_data[rd_ptr] : 32'd0;
  end

  // Shadow register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) shadow[i] <= 32'd0;
    end else if (wb_write) begin
      shadow[wb_addr] <= wb_data;
    end
  end

  // FIFO storage; contents need no reset since the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_addr[wr_ptr] <= wb_addr;
      fifo_data[wr_ptr] <= wb_data;
    end
  end

  // Pointers, occupancy and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      trace_count <= '0;
      overflow    <= 1'b0;
      drop_count  <= 8'd0;
      wb_count    <= 16'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   trace_count <= trace_count + CW'(1);
        2'b01:   trace_count <= trace_count - CW'(1);
        default: trace_count <= trace_count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
      if (wb_valid) wb_count <= wb_count + 16'd1;
    end
  end

endmodule
